// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select encodings,
// the per-stage destination record and the opcode constants used by the decoder.
package hazard_ctrl_pkg;

    // Register index and record field widths
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned FWD_SEL_W = 2;

    // Operand source selects
    localparam logic [FWD_SEL_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_EX  = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_SEL_W-1:0] FWD_WB  = 2'b11;

    // RV32I major opcodes, shared with the decoder
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Destination record carried down EX/MEM/WB
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 we;
        logic                 mem_read;
    } rec_t;

    localparam rec_t REC_BUBBLE = '0;

    // A record produces a value the reading operand needs; x0 never produces anything
    function automatic logic rec_hit(input rec_t r, input logic [REG_IDX_W-1:0] rs,
                                     input logic re);
        return r.valid & r.we & (r.rd != '0) & (r.rd == rs) & re;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Priority forwarding select for one operand: the youngest in-flight writer wins.
// A load sitting in EX cannot be forwarded yet, so it reports load_hit instead.
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_IDX_W-1:0] rs,
    input  logic                 re,
    input  rec_t                 ex_r,
    input  rec_t                 mem_r,
    input  rec_t                 wb_r,
    output logic [FWD_SEL_W-1:0] sel,
    output logic                 load_hit,
    output logic                 any_hit
);

    logic hit_ex, hit_mem, hit_wb;

    // Only the EX record's load flag matters here
    logic unused_mem_read;
    assign unused_mem_read = mem_r.mem_read ^ wb_r.mem_read;

    // Per-stage match against this operand
    always_comb begin
        hit_ex  = rec_hit(ex_r, rs, re);
        hit_mem = rec_hit(mem_r, rs, re);
        hit_wb  = rec_hit(wb_r, rs, re);
    end

    // Youngest-first priority; loads in EX stall rather than forward
    always_comb begin
        sel      = FWD_RF;
        load_hit = 1'b0;
        any_hit  = hit_ex | hit_mem | hit_wb;
        if (hit_ex) begin
            if (ex_r.mem_read) begin
                load_hit = 1'b1;
            end else begin
                sel = FWD_EX;
            end
        end else if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
        // Without bypass paths every operand comes from the register file
        if (!FWD_EN) begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core. Tracks EX/MEM/WB destination records,
// raises load-use (or RAW, without forwarding) stalls, flushes on taken redirects,
// drives operand forwarding selects and counts stall cycles and redirect events.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rD1_re,
    input  logic                 id_rD2_re,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_reg_we,
    input  logic                 id_mem_read,
    input  logic                 ex_taken,
    output logic                 stall_pc,
    output logic                 stall_if_id,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic [FWD_SEL_W-1:0] fwd_a_sel,
    output logic [FWD_SEL_W-1:0] fwd_b_sel,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rec_t ex_r, mem_r, wb_r;
    rec_t id_rec;
    logic load_a, load_b, any_a, any_b;
    logic hazard, stall, flush;

    hazard_ctrl_fwd_sel #(
        .FWD_EN(FWD_EN)
    ) u_fwd_a (
        .rs      (id_rs1),
        .re      (id_rD1_re),
        .ex_r    (ex_r),
        .mem_r   (mem_r),
        .wb_r    (wb_r),
        .sel     (fwd_a_sel),
        .load_hit(load_a),
        .any_hit (any_a)
    );

    hazard_ctrl_fwd_sel #(
        .FWD_EN(FWD_EN)
    ) u_fwd_b (
        .rs      (id_rs2),
        .re      (id_rD2_re),
        .ex_r    (ex_r),
        .mem_r   (mem_r),
        .wb_r    (wb_r),
        .sel     (fwd_b_sel),
        .load_hit(load_b),
        .any_hit (any_b)
    );

    // Record of the instruction currently in ID
    always_comb begin
        id_rec          = REC_BUBBLE;
        id_rec.valid    = id_valid;
        id_rec.rd       = id_rd;
        id_rec.we       = id_reg_we;
        id_rec.mem_read = id_mem_read;
    end

    // Hazard detection; a redirect makes the ID instruction wrong-path, so flush wins
    always_comb begin
        flush  = ex_r.valid & ex_taken;
        hazard = FWD_EN ? (load_a | load_b) : (any_a | any_b);
        stall  = id_valid & hazard & ~flush;
    end

    // Pipeline control outputs
    always_comb begin
        stall_pc    = stall;
        stall_if_id = stall;
        flush_if_id = flush;
        flush_id_ex = stall | flush;
    end

    // Shadow of the EX/MEM/WB destination records; a bubble enters EX on stall or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_r  <= REC_BUBBLE;
            mem_r <= REC_BUBBLE;
            wb_r  <= REC_BUBBLE;
        end else begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            ex_r  <= (stall | flush) ? REC_BUBBLE : id_rec;
        end
    end

    // Saturating stall-cycle and redirect-event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one forwarding instance (32-bit counters) and one
// non-forwarding instance (3-bit counters) share the same ID/EX stimulus.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rD1_re, id_rD2_re, id_reg_we, id_mem_read, ex_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        stall_pc0, stall_if_id0, flush_if_id0, flush_id_ex0;
    logic [1:0]  fwd_a_sel0, fwd_b_sel0;
    logic [31:0] stall_cnt0, flush_cnt0;
    logic        stall_pc1, stall_if_id1, flush_if_id1, flush_id_ex1;
    logic [1:0]  fwd_a_sel1, fwd_b_sel1;
    logic [2:0]  stall_cnt1, flush_cnt1;

    hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rD1_re(id_rD1_re), .id_rD2_re(id_rD2_re), .id_rd(id_rd), .id_reg_we(id_reg_we),
        .id_mem_read(id_mem_read), .ex_taken(ex_taken), .stall_pc(stall_pc0),
        .stall_if_id(stall_if_id0), .flush_if_id(flush_if_id0), .flush_id_ex(flush_id_ex0),
        .fwd_a_sel(fwd_a_sel0), .fwd_b_sel(fwd_b_sel0), .stall_cnt(stall_cnt0),
        .flush_cnt(flush_cnt0)
    );

    hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rD1_re(id_rD1_re), .id_rD2_re(id_rD2_re), .id_rd(id_rd), .id_reg_we(id_reg_we),
        .id_mem_read(id_mem_read), .ex_taken(ex_taken), .stall_pc(stall_pc1),
        .stall_if_id(stall_if_id1), .flush_if_id(flush_if_id1), .flush_id_ex(flush_id_ex1),
        .fwd_a_sel(fwd_a_sel1), .fwd_b_sel(fwd_b_sel1), .stall_cnt(stall_cnt1),
        .flush_cnt(flush_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] r1;
        logic       e1;
        logic [4:0] r2;
        logic       e2;
        logic [4:0] d;
        logic       w;
        logic       m;
    } ins_t;

    // In-flight instruction as seen by the reference model
    typedef struct {
        bit         v;
        logic [4:0] rd;
        bit         we;
        bit         ld;
    } ent_t;

    typedef struct {
        bit      stall;
        bit      flush;
        int      sel_a;
        int      sel_b;
        longint  scnt;
        longint  fcnt;
    } obs_t;

    typedef struct {
        obs_t m0;
        obs_t m1;
    } exp_t;

    exp_t   sb_q[$];
    ent_t   pipe[2][3];     // per instance: [0]=EX, [1]=MEM, [2]=WB
    longint scnt[2];
    longint fcnt[2];
    longint cmax[2];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic v, input logic [4:0] r1, input logic e1,
                                input logic [4:0] r2, input logic e2, input logic [4:0] d,
                                input logic w, input logic m);
        ins_t i;
        i = '{v: v, r1: r1, e1: e1, r2: r2, e2: e2, d: d, w: w, m: m};
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        return mk(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom));
    endfunction

    // Age (0=EX,1=MEM,2=WB) of the youngest in-flight writer of rs, or -1
    function automatic int producer(input int m, input logic [4:0] rs, input bit re);
        if (!re || rs == 5'd0) return -1;
        for (int k = 0; k < 3; k++) begin
            if (pipe[m][k].v && pipe[m][k].we && pipe[m][k].rd == rs) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 3; k++) pipe[m][k] = '{v: 0, rd: 5'd0, we: 0, ld: 0};
            scnt[m] = 0;
            fcnt[m] = 0;
        end
    endtask

    // Expected outputs for this cycle, then the state after the coming clock edge
    task automatic model_cycle(input int m, output obs_t o);
        int pa, pb;
        bit hz, luse_a, luse_b;
        ent_t nx;
        pa     = producer(m, id_rs1, id_rD1_re);
        pb     = producer(m, id_rs2, id_rD2_re);
        luse_a = (pa == 0) && pipe[m][0].ld;
        luse_b = (pb == 0) && pipe[m][0].ld;
        if (m == 0) begin
            hz      = luse_a || luse_b;
            o.sel_a = (pa < 0 || luse_a) ? 0 : pa + 1;
            o.sel_b = (pb < 0 || luse_b) ? 0 : pb + 1;
        end else begin
            hz      = (pa >= 0) || (pb >= 0);
            o.sel_a = 0;
            o.sel_b = 0;
        end
        o.flush = pipe[m][0].v && ex_taken;
        o.stall = id_valid && hz && !o.flush;
        o.scnt  = scnt[m];
        o.fcnt  = fcnt[m];
        if (o.stall && scnt[m] < cmax[m]) scnt[m]++;
        if (o.flush && fcnt[m] < cmax[m]) fcnt[m]++;
        if (o.stall || o.flush) nx = '{v: 0, rd: 5'd0, we: 0, ld: 0};
        else nx = '{v: id_valid, rd: id_rd, we: id_reg_we, ld: id_mem_read};
        pipe[m][2] = pipe[m][1];
        pipe[m][1] = pipe[m][0];
        pipe[m][0] = nx;
    endtask

    // One clock cycle of stimulus; inputs change on the falling edge
    task automatic cyc(input bit r, input ins_t i, input bit t);
        exp_t e;
        @(negedge clk);
        rst         = r;
        id_valid    = i.v;
        id_rs1      = i.r1;
        id_rD1_re   = i.e1;
        id_rs2      = i.r2;
        id_rD2_re   = i.e2;
        id_rd       = i.d;
        id_reg_we   = i.w;
        id_mem_read = i.m;
        ex_taken    = t;
        #1;
        if (r) begin
            model_reset();
            e.m0 = '{stall: 0, flush: 0, sel_a: 0, sel_b: 0, scnt: 0, fcnt: 0};
            e.m1 = e.m0;
        end else begin
            model_cycle(0, e.m0);
            model_cycle(1, e.m1);
        end
        sb_q.push_back(e);
    endtask

    // Monitor: compare every presented output set against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("d0_stall_pc", 64'(stall_pc0), 64'(e.m0.stall));
                chk("d0_stall_if_id", 64'(stall_if_id0), 64'(e.m0.stall));
                chk("d0_flush_if_id", 64'(flush_if_id0), 64'(e.m0.flush));
                chk("d0_flush_id_ex", 64'(flush_id_ex0), 64'(e.m0.stall | e.m0.flush));
                chk("d0_fwd_a", 64'(fwd_a_sel0), 64'(e.m0.sel_a));
                chk("d0_fwd_b", 64'(fwd_b_sel0), 64'(e.m0.sel_b));
                chk("d0_stall_cnt", 64'(stall_cnt0), 64'(e.m0.scnt));
                chk("d0_flush_cnt", 64'(flush_cnt0), 64'(e.m0.fcnt));
                chk("d1_stall_pc", 64'(stall_pc1), 64'(e.m1.stall));
                chk("d1_stall_if_id", 64'(stall_if_id1), 64'(e.m1.stall));
                chk("d1_flush_if_id", 64'(flush_if_id1), 64'(e.m1.flush));
                chk("d1_flush_id_ex", 64'(flush_id_ex1), 64'(e.m1.stall | e.m1.flush));
                chk("d1_fwd_a", 64'(fwd_a_sel1), 64'(e.m1.sel_a));
                chk("d1_fwd_b", 64'(fwd_b_sel1), 64'(e.m1.sel_b));
                chk("d1_stall_cnt", 64'(stall_cnt1), 64'(e.m1.scnt));
                chk("d1_flush_cnt", 64'(flush_cnt1), 64'(e.m1.fcnt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ins_t nop, lw5, add651, addi3, addi4, add734, addi0, add200, lui9, jal9, add433;
        nop    = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
        lw5    = mk(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
        add651 = mk(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        addi3  = mk(1, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0);
        addi4  = mk(1, 5'd0, 1, 5'd0, 0, 5'd4, 1, 0);
        add734 = mk(1, 5'd3, 1, 5'd4, 1, 5'd7, 1, 0);
        addi0  = mk(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0);
        add200 = mk(1, 5'd0, 1, 5'd0, 1, 5'd2, 1, 0);
        lui9   = mk(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
        jal9   = mk(1, 5'd9, 0, 5'd9, 0, 5'd1, 1, 0);
        add433 = mk(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        cmax[0] = 64'hFFFF_FFFF;
        cmax[1] = 7;
        model_reset();
        rst = 1'b1;
        {id_valid, id_rD1_re, id_rD2_re, id_reg_we, id_mem_read, ex_taken} = '0;
        {id_rs1, id_rs2, id_rd} = '0;

        // Reset held three cycles under random ID traffic
        for (int k = 0; k < 3; k++) cyc(1, rnd_ins(), 1'($urandom));
        #2 chk("rst_stall_cnt", 64'(stall_cnt0), 64'd0);

        // Load-use: one stall cycle, then MEM forwarding
        cyc(0, lw5, 0);
        cyc(0, add651, 0);
        #2 chk("lu_stall_pc", 64'(stall_pc0), 64'd1);
        chk("lu_flush_id_ex", 64'(flush_id_ex0), 64'd1);
        chk("lu_fwd_a_during", 64'(fwd_a_sel0), 64'd0);
        cyc(0, add651, 0);
        #2 chk("lu_after_stall", 64'(stall_pc0), 64'd0);
        chk("lu_fwd_a", 64'(fwd_a_sel0), 64'd2);
        chk("lu_fwd_b", 64'(fwd_b_sel0), 64'd0);
        chk("lu_stall_cnt", 64'(stall_cnt0), 64'd1);

        // Back-to-back ALU producers
        cyc(1, nop, 0);
        cyc(0, addi3, 0);
        cyc(0, addi4, 0);
        cyc(0, add734, 0);
        #2 chk("b2b_fwd_a", 64'(fwd_a_sel0), 64'd2);
        chk("b2b_fwd_b", 64'(fwd_b_sel0), 64'd1);
        chk("b2b_stall", 64'(stall_pc0), 64'd0);

        // x0 writer and disabled read enables never hit
        cyc(1, nop, 0);
        cyc(0, addi0, 0);
        cyc(0, add200, 0);
        #2 chk("x0_fwd_a", 64'(fwd_a_sel0), 64'd0);
        chk("x0_stall", 64'(stall_pc1), 64'd0);
        cyc(0, lui9, 0);
        cyc(0, jal9, 0);
        #2 chk("re_fwd_a", 64'(fwd_a_sel0), 64'd0);
        chk("re_stall", 64'(stall_pc1), 64'd0);

        // Redirect beats a simultaneous load-use
        cyc(1, nop, 0);
        cyc(0, lw5, 0);
        cyc(0, add651, 1);
        #2 chk("fl_flush_if_id", 64'(flush_if_id0), 64'd1);
        chk("fl_flush_id_ex", 64'(flush_id_ex0), 64'd1);
        chk("fl_stall_pc", 64'(stall_pc0), 64'd0);
        cyc(0, nop, 0);
        #2 chk("fl_flush_cnt", 64'(flush_cnt0), 64'd1);
        chk("fl_stall_cnt", 64'(stall_cnt0), 64'd0);

        // No forwarding: three stall cycles per RAW, counter saturates at 7
        cyc(1, nop, 0);
        for (int g = 0; g < 3; g++) begin
            cyc(0, addi3, 0);
            cyc(0, add433, 0);
            #2 chk("raw_stall", 64'(stall_pc1), 64'd1);
            chk("raw_fwd_a", 64'(fwd_a_sel1), 64'd0);
            for (int k = 0; k < 3; k++) cyc(0, add433, 0);
            #2 chk("raw_released", 64'(stall_pc1), 64'd0);
            chk("raw_stall_cnt", 64'(stall_cnt1), (g == 2) ? 64'd7 : 64'(3 * (g + 1)));
        end

        // Reset asserted in the middle of a stall
        cyc(1, nop, 0);
        cyc(0, lw5, 0);
        cyc(0, add651, 0);
        #2 chk("mid_pre_stall", 64'(stall_pc0), 64'd1);
        cyc(1, add651, 0);
        #2 chk("mid_stall_pc", 64'(stall_pc0), 64'd0);
        chk("mid_flush_id_ex", 64'(flush_id_ex0), 64'd0);
        chk("mid_stall_cnt", 64'(stall_cnt0), 64'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 500; n++) begin
            cyc(($urandom_range(0, 59) == 0), rnd_ins(), ($urandom_range(0, 5) == 0));
        end

        repeat (2) @(negedge clk);
        #5 chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Consumes the ID-stage decode signals: register read enables, branch, mem_read, reg_we.
- Keeps its own registered shadow of the EX/MEM/WB destination records.
- Drives PC/IF-ID stall, IF-ID/ID-EX flush, per-operand forwarding selects and saturating stall/flush event counters.

Parameters:
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall on any RAW hit in EX/MEM/WB until the writer retires.
- CNT_W, 32, width of the stall_cnt and flush_cnt counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  rs1 index
- id_rs2  in  5  rs2 index
- id_rD1_re  in  1  rs1 is read
- id_rD2_re  in  1  rs2 is read
- id_rd  in  5  destination index
- id_reg_we  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- ex_taken  in  1  EX-stage branch/jal/jalr redirects PC this cycle
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- flush_if_id  out  1  load NOP into IF/ID
- flush_id_ex  out  1  load bubble into ID/EX
- fwd_a_sel  out  2  operand A source: 00 regfile, 01 EX result, 10 MEM result, 11 WB data
- fwd_b_sel  out  2  operand B source, same encoding
- stall_cnt  out  CNT_W  cycles with stall asserted
- flush_cnt  out  CNT_W  redirect events

Behaviour:
- State: three records ex_r, mem_r, wb_r, each {valid, rd[4:0], we, mem_read}. Reset clears every field to 0.
- Record advance, each clock:
  - wb_r <= mem_r; mem_r <= ex_r.
  - ex_r <= ID record {id_valid, id_rd, id_reg_we, id_mem_read}, unless stall or flush is active; then ex_r <= bubble (valid=0).
- A record "hits" a source when: record.valid & record.we & record.rd != 0 & rd == rs & the matching read enable is set. rd == 0 never hits.
- Load-use stall (FWD_EN=1): ID source hits ex_r with ex_r.mem_read=1.
- RAW stall (FWD_EN=0): ID source hits any of ex_r, mem_r, wb_r.
- stall = id_valid & hazard & !flush. While stalled, stall_pc = stall_if_id = flush_id_ex = 1.
- flush = ex_r.valid & ex_taken.
  - flush_if_id = flush_id_ex = 1; stall forced 0, since the ID instruction is wrong-path.
  - Flush has priority over stall in the same cycle.
- Forwarding (FWD_EN=1), per operand, combinational:
  - Youngest hit wins: ex_r, then mem_r, then wb_r, else 00.
  - An ex_r hit that is a load never selects 01; it raises stall instead and the select shows 00.
  - With FWD_EN=0, selects are constant 00.
- Control outputs are combinational from the records and ID inputs. Reset values: all 0, selects 00.
- Latency:
  - Load-use costs exactly 1 stall cycle; the next cycle the load is in mem_r and the select is 10.
  - A taken redirect costs 2 bubbles (IF/ID and ID/EX).
- Counters:
  - stall_cnt increments on every cycle stall_pc=1.
  - flush_cnt increments on every cycle flush=1.
  - Both saturate at all-ones and clear on reset.
- Reset asserted mid-stall or mid-flush: all records and counters clear immediately (async). Outputs drop to 0 in the same cycle.

Decomposition:
- Shared header hazard_defs.vh holds:
  - FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_MEM = 2'b10, FWD_WB = 2'b11.
  - Record field widths.
  - The opcode constants already used by the decoder.
- Sub-module fwd_sel: combinational priority select for one operand. Inputs are rs, re and the three records; outputs are sel[1:0] and load_hit. Instantiated twice, for A and B.

Test Plan:
- Reset: assert rst for 3 cycles with random ID inputs -> all outputs 0, selects 00, counters 0.
- Load-use: lw x5 then add x6,x5,x1 -> stall_pc=stall_if_id=flush_id_ex=1 for 1 cycle; next cycle fwd_a_sel=10, fwd_b_sel=00; stall_cnt=1.
- Back-to-back ALU: addi x3; addi x4; add x7,x3,x4 -> at the add's ID cycle fwd_a_sel=10, fwd_b_sel=01; no stall.
- x0 and read enable: addi x0 then add x2,x0,x0 -> selects 00, no stall. lui x9 then jal using rd=x9 with id_rD1_re=0 -> no hit.
- Flush vs stall: taken beq in EX while the ID instruction is a load-use -> flush_if_id=flush_id_ex=1, stall_pc=0; flush_cnt=1, stall_cnt unchanged.
- FWD_EN=0: addi x3 then add x4,x3,x3 -> stall 3 cycles, selects stay 00, stall_cnt=3. Also preload stall_cnt near all-ones and check it saturates at all-ones.
